mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single shared memory port, with an
// ack watchdog. Define ARB_RR_EN for round-robin tie-break instead of fixed dm priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              if_stall_o,
    output logic              dm_stall_o,
    output logic              err_o
);

    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             if_flushed;
    logic             if_elig;
    logic             dm_elig;
    logic             pick_dm;
    logic             timeout_hit;

    // A requester is ignored in the cycle its done pulse is showing
    assign if_elig = if_req_i & ~if_done_o & ~if_flush_i;
    assign dm_elig = dm_req_i & ~dm_done_o;

    assign timeout_hit = (TO_LIM != '0) && (wait_cnt == TO_LIM - CNT_W'(1));

    assign if_stall_o = if_req_i & ~if_done_o;
    assign dm_stall_o = dm_req_i & ~dm_done_o;

`ifdef ARB_RR_EN
    logic last_dm;

    // Tie goes to whichever side was not granted last
    assign pick_dm = dm_elig & (~if_elig | ~last_dm);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_dm <= 1'b0;
        end else if (state == IDLE && (dm_elig || if_elig)) begin
            last_dm <= pick_dm;
        end
    end
`else
    assign pick_dm = dm_elig;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            if_flushed  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            if_done_o   <= 1'b0;
            dm_done_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if_done_o <= 1'b0;
            dm_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt   <= '0;
                    if_flushed <= 1'b0;
                    if (pick_dm) begin
                        state       <= GNT_DM;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                    end else if (if_elig) begin
                        state       <= GNT_IF;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                    end
                end
                GNT_IF: begin
                    // A flush seen at any point in the grant cancels the result
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (!(if_flushed || if_flush_i)) begin
                            if_rdata_o <= mem_rdata_i;
                            if_done_o  <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        err_o     <= 1'b1;
                        if (!(if_flushed || if_flush_i)) begin
                            if_rdata_o <= '0;
                            if_done_o  <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (if_flush_i) begin
                            if_flushed <= 1'b1;
                        end
                    end
                end
                GNT_DM: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        dm_done_o <= 1'b1;
                        if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        err_o      <= 1'b1;
                        dm_rdata_o <= '0;
                        dm_done_o  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
